lu_cmd_issuer: RTL and testbench

Initiator side of the 16-bit logic unit interface. Accepts opcode/operand commands over a valid/ready handshake and buffers them in a small FIFO. Drives registered select/operand lines into the combinational logic unit, captures its result, and returns it over a valid/ready response channel. Sits between the control/test sequencer and the logic unit datapath.

---
 rtl/lu_cmd_issuer.sv | 164 ++++++++++++++++
 tb/tb_lu_cmd_issuer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lu_cmd_issuer.sv
// lu_cmd_issuer: initiator side of the 16-bit logic unit interface.
// Commands are queued in a DEPTH-entry FIFO, issued to the combinational
// logic unit on registered lu_* lines, and the captured result is returned
// over a valid/ready response channel.
// Optional build macro LU_CHECK_EN adds a reference model that flags
// result mismatches on rsp_err; without it rsp_err is tied low.
//
// state | meaning
// IDLE  | nothing in flight; pop the FIFO head when one is available
// ISSUE | lu_* stable for one full cycle while the logic unit settles
// RESP  | result captured; hold rsp_* until the consumer accepts
module lu_cmd_issuer #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [15:0]      cmd_a,
   input  logic [15:0]      cmd_b,
   output logic [2:0]       lu_sel,
   output logic [15:0]      lu_a,
   output logic [15:0]      lu_b,
   input  logic [15:0]      lu_res,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [15:0]      rsp_data,
   output logic [2:0]       rsp_op,
   output logic             rsp_zero,
   output logic             rsp_err,
   output logic             busy,
   output logic [CNT_W-1:0] done_cnt
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t          state;
   logic [34:0]     mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     count;
   logic [AW:0]     count_next;
   logic            push;
   logic            pop;
   logic [34:0]     head;

   // a pop only ever happens when the FSM is free to take a new command
   assign push = cmd_valid && cmd_ready;
   assign pop  = (count != '0) &&
                 ((state == IDLE) || ((state == RESP) && rsp_ready));
   assign head = mem[rd_ptr];
   assign busy = (count != '0) || (state != IDLE);

   // occupancy after this edge; drives the registered cmd_ready
   always_comb begin
      count_next = count;
      if (push && !pop)
         count_next = count + (AW+1)'(1);
      else if (pop && !push)
         count_next = count - (AW+1)'(1);
   end

   // FIFO storage; contents need no reset since count gates every read
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b};
   end

   // FIFO pointers, occupancy and registered ready
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         cmd_ready <= 1'b1;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         count     <= count_next;
         cmd_ready <= (count_next != (AW+1)'(DEPTH));
      end
   end

   // issue/capture/response sequencing with registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         lu_sel    <= '0;
         lu_a      <= '0;
         lu_b      <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_op    <= '0;
         rsp_zero  <= 1'b0;
         done_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  {lu_sel, lu_a, lu_b} <= head;
                  state                <= ISSUE;
               end
            end
            ISSUE: begin
               rsp_data  <= lu_res;
               rsp_op    <= lu_sel;
               rsp_zero  <= (lu_res == 16'h0000);
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  done_cnt  <= done_cnt + CNT_W'(1);
                  rsp_valid <= 1'b0;
                  if (pop) begin
                     {lu_sel, lu_a, lu_b} <= head;
                     state                <= ISSUE;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef LU_CHECK_EN
   logic [15:0] lu_expect;

   // reference model of the logic unit from the issued select/operands
   always_comb begin
      lu_expect = 16'h0000;
      case (lu_sel)
         3'b000: lu_expect = lu_a & lu_b;
         3'b001: lu_expect = lu_a | lu_b;
         3'b010: lu_expect = ~(lu_a & lu_b);
         3'b011: lu_expect = ~(lu_a | lu_b);
         3'b100: lu_expect = ~lu_a;
         3'b101: lu_expect = lu_a ^ lu_b;
         3'b110: lu_expect = ~(lu_a ^ lu_b);
         3'b111: lu_expect = ~lu_a + 16'h0001;
         default: lu_expect = 16'h0000;
      endcase
   end

   // mismatch flag captured alongside rsp_data and held through RESP
   always_ff @(posedge clk) begin
      if (reset)
         rsp_err <= 1'b0;
      else if (state == ISSUE)
         rsp_err <= (lu_res != lu_expect);
   end
`else
   assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_lu_cmd_issuer.sv
// Directed bench for lu_cmd_issuer: single command latency, all opcodes,
// backpressure with a full FIFO, zero/boundary results, reset mid-operation
// and, when built with LU_CHECK_EN, the result-mismatch flag.
module tb_lu_cmd_issuer;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [15:0] cmd_a;
   logic [15:0] cmd_b;
   logic [2:0]  lu_sel;
   logic [15:0] lu_a;
   logic [15:0] lu_b;
   logic [15:0] lu_res;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data;
   logic [2:0]  rsp_op;
   logic        rsp_zero;
   logic        rsp_err;
   logic        busy;
   logic [7:0]  done_cnt;
   logic        lu_flip;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   typedef struct packed {
      logic [15:0] data;
      logic [2:0]  op;
      logic        zero;
      logic        err;
      logic [31:0] at;
   } rsp_t;

   rsp_t rsp_q[$];

   lu_cmd_issuer #(.DEPTH(4), .CNT_W(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .lu_sel    (lu_sel),
      .lu_a      (lu_a),
      .lu_b      (lu_b),
      .lu_res    (lu_res),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_op    (rsp_op),
      .rsp_zero  (rsp_zero),
      .rsp_err   (rsp_err),
      .busy      (busy),
      .done_cnt  (done_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // stand-in for the combinational logic unit, with an optional bit-0 fault
   function automatic logic [15:0] lu_model(input logic [2:0] s,
                                            input logic [15:0] a,
                                            input logic [15:0] b);
      case (s)
         3'b000:  return a & b;
         3'b001:  return a | b;
         3'b010:  return ~(a & b);
         3'b011:  return ~(a | b);
         3'b100:  return ~a;
         3'b101:  return a ^ b;
         3'b110:  return ~(a ^ b);
         default: return ~a + 16'h0001;
      endcase
   endfunction

   assign lu_res = lu_model(lu_sel, lu_a, lu_b) ^ {15'b0, lu_flip};

   // record every response handshake, sampled away from the clock edge
   always @(negedge clk) begin
      if (!reset && rsp_valid && rsp_ready)
         rsp_q.push_back('{rsp_data, rsp_op, rsp_zero, rsp_err, 32'(cyc)});
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, output int pcyc);
      bit ok;
      ok        = 1'b0;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      pcyc      = cyc;
      if (!ok) check("push_timeout", 32'(ok), 32'd1);
   endtask

   task automatic wait_rsp(input int n);
      for (int i = 0; i < 200 && rsp_q.size() < n; i++) @(posedge clk);
      #1;
      check("rsp_count", 32'(rsp_q.size()), 32'(n));
   endtask

   task automatic check_rsp(input int idx, input logic [15:0] exp_data,
                            input logic [2:0] exp_op, input logic exp_zero,
                            input logic exp_err);
      if (idx < rsp_q.size()) begin
         check("rsp_data", 32'(rsp_q[idx].data), 32'(exp_data));
         check("rsp_op",   32'(rsp_q[idx].op),   32'(exp_op));
         check("rsp_zero", 32'(rsp_q[idx].zero), 32'(exp_zero));
         check("rsp_err",  32'(rsp_q[idx].err),  32'(exp_err));
      end else begin
         check("rsp_missing", 32'(rsp_q.size()), 32'(idx + 1));
      end
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   localparam logic [15:0] ALL_OPS_EXP [8] = '{
      16'h000F, 16'h0FFF, 16'hFFF0, 16'hF000,
      16'hFF00, 16'h0FF0, 16'hF00F, 16'hFF01
   };

   initial begin
      int pc;
      int acc;
      logic [15:0] exp_v;

      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = '0;
      cmd_a     = '0;
      cmd_b     = '0;
      rsp_ready = 1'b1;
      lu_flip   = 1'b0;
      idle_cycles(3);
      reset = 1'b0;

      // reset state
      @(negedge clk);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_done_cnt",  32'(done_cnt),  32'd0);
      check("rst_lu",        {13'd0, lu_sel, lu_a}, 32'd0);
      check("rst_rsp_data",  32'(rsp_data),  32'd0);
      check("rst_rsp_err",   32'(rsp_err),   32'd0);
      @(posedge clk); #1;

      // single command with two-edge latency
      rsp_q.delete();
      push(3'b000, 16'hF0F0, 16'hFF00, pc);
      wait_rsp(1);
      check_rsp(0, 16'hF000, 3'b000, 1'b0, 1'b0);
      if (rsp_q.size() > 0) check("latency", rsp_q[0].at, 32'(pc + 2));
      idle_cycles(2);
      check("done_single", 32'(done_cnt), 32'd1);

      // every opcode back to back
      rsp_q.delete();
      for (int i = 0; i < 8; i++) push(3'(i), 16'h00FF, 16'h0F0F, pc);
      wait_rsp(8);
      for (int i = 0; i < 8; i++) check_rsp(i, ALL_OPS_EXP[i], 3'(i), 1'b0, 1'b0);
      for (int i = 1; i < 8 && i < rsp_q.size(); i++)
         check("spacing", rsp_q[i].at - rsp_q[i-1].at, 32'd2);
      idle_cycles(3);
      check("done_ops", 32'(done_cnt), 32'd9);
      check("busy_after_ops", 32'(busy), 32'd0);

      // backpressure: one stuck in RESP plus a full FIFO
      rsp_q.delete();
      rsp_ready = 1'b0;
      acc = 0;
      for (int i = 1; i <= 6; i++) begin
         cmd_valid = 1'b1;
         cmd_op    = 3'b001;
         cmd_a     = 16'(i * 16'h0100);
         cmd_b     = 16'(i);
         @(negedge clk);
         if (cmd_ready) acc++;
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      check("accepted", 32'(acc), 32'd5);
      check("full_ready", 32'(cmd_ready), 32'd0);
      check("held_valid", 32'(rsp_valid), 32'd1);
      check("held_data0", 32'(rsp_data), 32'h0101);
      idle_cycles(3);
      check("held_data1", 32'(rsp_data), 32'h0101);
      check("still_full", 32'(cmd_ready), 32'd0);
      rsp_ready = 1'b1;
      wait_rsp(5);
      for (int i = 1; i <= 5; i++) begin
         exp_v = 16'(i * 16'h0101);
         check_rsp(i - 1, exp_v, 3'b001, 1'b0, 1'b0);
      end
      idle_cycles(4);
      check("drained_count", 32'(rsp_q.size()), 32'd5);
      check("busy_drained", 32'(busy), 32'd0);
      check("done_bp", 32'(done_cnt), 32'd14);

      // zero and two's-complement boundaries
      rsp_q.delete();
      push(3'b100, 16'hFFFF, 16'h1234, pc);
      push(3'b111, 16'h0000, 16'hFFFF, pc);
      push(3'b111, 16'h8000, 16'h0000, pc);
      wait_rsp(3);
      check_rsp(0, 16'h0000, 3'b100, 1'b1, 1'b0);
      check_rsp(1, 16'h0000, 3'b111, 1'b1, 1'b0);
      check_rsp(2, 16'h8000, 3'b111, 1'b0, 1'b0);
      idle_cycles(3);
      check("done_bound", 32'(done_cnt), 32'd17);

      // reset while a command is in ISSUE with two more queued
      rsp_ready = 1'b0;
      push(3'b000, 16'hFFFF, 16'hFFFF, pc);
      push(3'b101, 16'h1111, 16'h2222, pc);
      push(3'b001, 16'h3333, 16'h4444, pc);
      push(3'b010, 16'h5555, 16'h6666, pc);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      reset     = 1'b1;
      check("pre_rst_done", 32'(done_cnt), 32'd18);
      check("pre_rst_lu_a", 32'(lu_a), 32'h1111);
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_valid", 32'(rsp_valid), 32'd0);
      check("mid_rst_busy",  32'(busy),      32'd0);
      check("mid_rst_done",  32'(done_cnt),  32'd0);
      check("mid_rst_lu",    {13'd0, lu_sel, lu_a}, 32'd0);
      check("mid_rst_lu_b",  32'(lu_b),      32'd0);
      @(posedge clk); #1;
      reset     = 1'b0;
      rsp_ready = 1'b1;
      rsp_q.delete();
      idle_cycles(10);
      check("no_stale", 32'(rsp_q.size()), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);

      // recovery after reset
      push(3'b110, 16'h1234, 16'h1234, pc);
      wait_rsp(1);
      check_rsp(0, 16'hFFFF, 3'b110, 1'b0, 1'b0);
      idle_cycles(2);
      check("done_recover", 32'(done_cnt), 32'd1);

`ifdef LU_CHECK_EN
      // injected bit-0 fault on the logic unit result
      rsp_q.delete();
      lu_flip = 1'b1;
      push(3'b101, 16'hAAAA, 16'h5555, pc);
      wait_rsp(1);
      lu_flip = 1'b0;
      check_rsp(0, 16'hFFFE, 3'b101, 1'b0, 1'b1);
      push(3'b000, 16'hAAAA, 16'h5555, pc);
      wait_rsp(2);
      check_rsp(1, 16'h0000, 3'b000, 1'b1, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
